// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_stage_pkg;

    // Word presented to decode when no instruction is available
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Sequential fetch stride and the distance from inst to its second successor
    localparam logic [31:0] PC_INCR  = 32'd4;
    localparam logic [31:0] PC_INCR2 = 32'd8;

    // Request-side state: normal streaming, an in-flight request whose word
    // must be thrown away, or a redirect waiting for its delay slot to be acked
    typedef enum logic [1:0] {
        REQ_RUN     = 2'd0,
        REQ_SQUASH  = 2'd1,
        REQ_PENDING = 2'd2
    } req_state_t;

    // Fetch addresses are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/adder_32.sv
// Plain 32-bit modulo adder used for the PC+4 / PC+8 paths.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_skid_buf.sv
// Two-deep fetch buffer: the output buffer feeding decode plus a hold
// register that catches a word arriving while decode is stalled.
module fetch_skid_buf
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        consume,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    input  logic [31:0] in_pc,
    input  logic [31:0] fill_pc4,
    input  logic [31:0] fill_pc8,
    output logic        buf_valid,
    output logic [31:0] buf_word,
    output logic [31:0] buf_pc4,
    output logic [31:0] buf_pc8,
    output logic        hold_valid,
    output logic [31:0] hold_pc
);

    logic [31:0] hold_word;

    // Refill the buffer from hold first, then the arriving word, else a bubble;
    // a word that cannot enter the full buffer parks in hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid  <= 1'b0;
            buf_word   <= 32'h0;
            buf_pc4    <= 32'h0;
            buf_pc8    <= 32'h0;
            hold_valid <= 1'b0;
            hold_word  <= 32'h0;
            hold_pc    <= 32'h0;
        end else if (flush) begin
            buf_valid  <= 1'b0;
            buf_word   <= NOP_WORD;
            hold_valid <= 1'b0;
        end else if (consume || !buf_valid) begin
            if (hold_valid) begin
                buf_valid  <= 1'b1;
                buf_word   <= hold_word;
                buf_pc4    <= fill_pc4;
                buf_pc8    <= fill_pc8;
                hold_valid <= in_valid;
                hold_word  <= in_word;
                hold_pc    <= in_pc;
            end else if (in_valid) begin
                buf_valid <= 1'b1;
                buf_word  <= in_word;
                buf_pc4   <= fill_pc4;
                buf_pc8   <= fill_pc8;
            end else begin
                buf_valid <= 1'b0;
                buf_word  <= NOP_WORD;
            end
        end else if (in_valid) begin
            hold_valid <= 1'b1;
            hold_word  <= in_word;
            hold_pc    <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory and applies decode redirects after the delay slot.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc4_out,
    output logic [31:0] pc8_out,
    output logic        inst_valid
);

    req_state_t  state;
    logic [31:0] req_addr;
    logic [31:0] redir_target;
    logic [31:0] target;
    logic [31:0] src_pc;
    logic [31:0] fill_pc4;
    logic [31:0] fill_pc8;
    logic [31:0] hold_pc;
    logic        buf_valid;
    logic        hold_valid;
    logic        fire;
    logic        redir;
    logic        case_a;
    logic        case_b;
    logic        deliver;

    // A request is open whenever there is room for its word; reset kills it at once
    assign imem_req  = !hold_valid && !reset;
    assign imem_addr = req_addr;
    assign fire      = imem_req && imem_ack;

    // Redirects only count on the edge where the branch actually leaves ID
    assign redir  = !stall && (branch_taken || jump);
    assign target = word_align(branch_taken ? branch_target : jump_target);
    // Delay slot already buffered (A) or still to come from memory (B)
    assign case_a = redir && buf_valid;
    assign case_b = redir && !buf_valid;

    // Words from a squashed request, or fetched past the delay slot, never reach decode
    assign deliver = fire && (state != REQ_SQUASH) && !case_a;

    // The word being placed into the buffer comes from hold if occupied, else from memory
    assign src_pc = hold_valid ? hold_pc : req_addr;

    adder_32 u_pc4 (.a(src_pc), .b(PC_INCR),  .sum(fill_pc4));
    adder_32 u_pc8 (.a(src_pc), .b(PC_INCR2), .sum(fill_pc8));

    fetch_skid_buf #(.NOP_WORD(NOP_WORD)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .consume    (!stall),
        .flush      (case_a),
        .in_valid   (deliver),
        .in_word    (imem_rdata),
        .in_pc      (req_addr),
        .fill_pc4   (fill_pc4),
        .fill_pc8   (fill_pc8),
        .buf_valid  (buf_valid),
        .buf_word   (inst_out),
        .buf_pc4    (pc4_out),
        .buf_pc8    (pc8_out),
        .hold_valid (hold_valid),
        .hold_pc    (hold_pc)
    );

    assign inst_valid = buf_valid;

    // Request address sequencing and redirect bookkeeping; the address never
    // moves while a request is waiting for its ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr     <= word_align(RESET_PC);
            redir_target <= 32'h0;
            state        <= REQ_RUN;
        end else if (case_a) begin
            if (imem_req && !imem_ack) begin
                state        <= REQ_SQUASH;
                redir_target <= target;
            end else begin
                req_addr <= target;
                state    <= REQ_RUN;
            end
        end else if (fire) begin
            case (state)
                REQ_SQUASH, REQ_PENDING: begin
                    req_addr <= redir_target;
                    state    <= REQ_RUN;
                end
                default: begin
                    req_addr <= case_b ? target : req_addr + PC_INCR;
                end
            endcase
        end else if (case_b) begin
            state        <= REQ_PENDING;
            redir_target <= target;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a program-order model of the
// instruction stream, a latency-randomising memory, and a decode stand-in.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc4_out;
    logic [31:0] pc8_out;
    logic        inst_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the architectural stream
    logic [31:0] exp_pc;
    logic [31:0] id_pc;
    bit          id_eligible;
    bit          pend;
    logic [31:0] pend_after;
    logic [31:0] pend_target;
    // Memory and protocol tracking
    int          wait_cnt;
    bit          prev_wait;
    logic [31:0] prev_addr;
    int          cyc;
    int          idle;
    int          delivered;

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_out      (inst_out),
        .pc4_out       (pc4_out),
        .pc8_out       (pc8_out),
        .inst_valid    (inst_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req",   {31'b0, imem_req},   32'h0);
        check("rst_inst",  inst_out,            32'h0);
        check("rst_pc4",   pc4_out,             32'h0);
        check("rst_pc8",   pc8_out,             32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        exp_pc      = 32'h0;
        id_pc       = 32'h0;
        id_eligible = 1'b0;
        pend        = 1'b0;
        wait_cnt    = 0;
        prev_wait   = 1'b0;
        cyc         = 0;
        idle        = 0;
    endtask

    // One clock of decode + memory behaviour, observed at the falling edge
    task automatic cycle(input bit rand_mode, input bit force_branch, input logic [31:0] force_target);
        logic [31:0] cur;
        logic [31:0] tgt;
        int          sel;
        bit          do_br;
        @(negedge clk);
        cyc++;

        // Output consistency every cycle
        if (!inst_valid) begin
            check("bubble_nop", inst_out, 32'h0);
        end else begin
            check("pc8_vs_pc4", pc8_out, pc4_out + 32'd4);
            check("inst_word", inst_out, mem_word(pc4_out - 32'd4));
        end
        check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (prev_wait) begin
            check("req_hold",  {31'b0, imem_req}, 32'h1);
            check("addr_hold", imem_addr, prev_addr);
        end

        // Hand-computed expectations for the directed start-up and branch
        if (!rand_mode) begin
            case (cyc)
                1: check("first_addr", imem_addr, 32'h0);
                2: begin
                    check("e1_addr",  imem_addr, 32'h4);
                    check("e1_valid", {31'b0, inst_valid}, 32'h1);
                    check("e1_inst",  inst_out, mem_word(32'h0));
                    check("e1_pc4",   pc4_out, 32'h4);
                    check("e1_pc8",   pc8_out, 32'h8);
                end
                3: begin
                    check("e2_addr", imem_addr, 32'h8);
                    check("e2_pc4",  pc4_out, 32'h8);
                    check("e2_pc8",  pc8_out, 32'hC);
                end
                4: begin
                    check("e3_pc4", pc4_out, 32'hC);
                    check("e3_pc8", pc8_out, 32'h10);
                end
                8: begin
                    check("br_bubble", {31'b0, inst_valid}, 32'h0);
                    check("br_addr",   imem_addr, 32'h40);
                end
                9: begin
                    check("br_tgt_pc4",  pc4_out, 32'h44);
                    check("br_tgt_inst", inst_out, mem_word(32'h40));
                end
                10: check("br_tgt1_pc4", pc4_out, 32'h48);
                default: ;
            endcase
        end

        // Decode stand-in: stall and redirect choices for the coming edge
        stall = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
        do_br = 1'b0;
        if (!stall && id_eligible && !pend)
            do_br = force_branch || (rand_mode && ($urandom_range(0, 5) == 0));
        if (force_branch && !do_br) begin
            n_checks++;
            n_fail++;
            $display("FAIL directed_branch_setup: ID not eligible (cycle %0d)", cyc);
        end
        if (do_br) begin
            tgt = $urandom;
            case ($urandom_range(0, 3))
                0: tgt = tgt;
                1: tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
                default: tgt = tgt & 32'h3FF;
            endcase
            if (force_branch) tgt = force_target;
            sel = force_branch ? 1 : $urandom_range(1, 3);
            branch_taken = (sel != 2);
            jump         = (sel != 1);
            if (branch_taken) begin
                branch_target = tgt;
                jump_target   = $urandom;
            end else begin
                jump_target   = tgt;
                branch_target = $urandom;
            end
            pend        = 1'b1;
            pend_after  = id_pc + 32'd4;
            pend_target = tgt & 32'hFFFF_FFFC;
        end else if (stall && rand_mode) begin
            branch_taken  = 1'($urandom_range(0, 1));
            jump          = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            jump_target   = $urandom;
        end else begin
            branch_taken = 1'b0;
            jump         = 1'b0;
        end

        // Stream model: what decode consumes at the coming edge
        if (!stall) begin
            if (inst_valid) begin
                cur = pc4_out - 32'd4;
                check("stream_pc", cur, exp_pc);
                delivered++;
                if (pend && cur == pend_after) begin
                    exp_pc      = pend_target;
                    pend        = 1'b0;
                    id_eligible = 1'b0;
                end else begin
                    exp_pc      = cur + 32'd4;
                    id_eligible = !pend;
                end
                id_pc = cur;
            end else begin
                id_eligible = 1'b0;
            end
        end

        if (inst_valid) idle = 0;
        else idle++;
        if (idle > 80) begin
            n_checks++;
            n_fail++;
            $display("FAIL progress: no valid instruction for %0d cycles (cycle %0d)", idle, cyc);
            idle = 0;
        end

        // Memory: ack after a random number of waiting cycles
        if (imem_req) begin
            if (wait_cnt == 0) begin
                imem_ack = 1'b1;
                wait_cnt = rand_mode ? $urandom_range(0, 3) : 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt--;
            end
        end else begin
            imem_ack = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        prev_wait = imem_req && !imem_ack;
        prev_addr = imem_addr;
    endtask

    task automatic run_directed();
        for (int i = 1; i <= 12; i++)
            cycle(1'b0, (i == 7), 32'h40);
    endtask

    initial begin
        bit found;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        branch_target = 32'h0;
        jump_target   = 32'h0;
        imem_ack      = 1'b0;
        delivered     = 0;
        cyc           = 0;

        repeat (2) @(posedge clk);
        #1 check_reset_outputs();

        release_reset();
        run_directed();
        repeat (3000) cycle(1'b1, 1'b0, 32'h0);

        // Reset while a request is waiting for its ack
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            if (prev_wait) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL midwait_setup: no waiting request found");
        end
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        release_reset();
        run_directed();
        repeat (1000) cycle(1'b1, 1'b0, 32'h0);

        n_checks++;
        if (delivered < 500) begin
            n_fail++;
            $display("FAIL throughput: delivered %0d required at least 500", delivered);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and drives a variable-latency instruction-memory request/acknowledge interface.
- Buffers up to two fetched words (output buffer plus hold register).
- Presents instruction, PC+4 and PC+8 to the decode stage's pipeline register, which samples them on every clock with stall low.
- Applies branch/jump redirects from decode, respecting the single architectural delay slot.

Parameters:
RESET_PC, 32'h0000_0000, address of first fetch after reset
NOP_WORD, 32'h0000_0000, word presented when no valid instruction (bubble)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  decode-stage hold; when high decode does not consume fetch outputs
branch_taken  in  1  decode resolved a taken branch this cycle
branch_target  in  32  branch destination
jump  in  1  decode holds j/jal/jr this cycle
jump_target  in  32  jump destination (register value for jr)
imem_req  out  1  fetch request valid
imem_addr  out  32  word address of request
imem_ack  in  1  request accepted, imem_rdata valid this cycle (may be combinational)
imem_rdata  in  32  instruction word
inst_out  out  32  instruction to decode (NOP_WORD when invalid)
pc4_out  out  32  address of inst_out + 4 (decode "delay" input)
pc8_out  out  32  address of inst_out + 8 (decode "delay2" input)
inst_valid  out  1  inst_out is a real fetched instruction

Behaviour:
- Reset (async): req_addr=RESET_PC, buf_valid=0, hold_valid=0, squash=0, redir_pending=0.
  - While reset is high: imem_req=0, inst_out=0, pc4_out=0, pc8_out=0, inst_valid=0.
  - Any outstanding memory request is abandoned; the memory must tolerate imem_req dropping.
- All outputs come from flops (pc4/pc8 via adders on the buffered pc).
- Request rule:
  - imem_req = !hold_valid, with imem_addr = req_addr.
  - Once imem_req is asserted without ack, req and addr stay stable until imem_ack. The request is never withdrawn, even after a squash.
- Accepting an ack:
  - On edge with req&&ack: req_addr <= req_addr+4, or the redirect target (see below).
  - If squash=1: discard the word and clear squash.
  - Else: write the word to the buffer if (buffer empty or consumed this edge), otherwise to the hold register.
- Consumption: the buffer is consumed at each edge with stall=0.
  - Refill priority: hold register first, then the arriving word, else a bubble (buf_valid<=0).
  - No word is lost or duplicated.
- Throughput: with ack tied high and stall=0, one instruction per cycle. The first valid inst_out appears 1 edge after reset release.
- Redirect sampling: redir = branch_taken|jump, sampled only on edges with stall=0 (the edge at which the branch leaves ID).
  - branch_taken has priority over jump if both are high.
  - Target = branch_target or jump_target.
- Case A, buf_valid=1 at the redirect edge: the buffer word is the delay slot and moves to ID normally.
  - Hold register is cleared.
  - Buffer loads a bubble.
  - If a request is outstanding and not acked this edge, set squash; if it is acked this edge, drop the word.
  - req_addr <= target (takes effect once any squashed request completes).
- Case B, buf_valid=0 at the redirect edge: set redir_pending with the target; the delay slot is still outstanding or unrequested.
  - The next accepted non-squashed word is the delay slot and is delivered normally.
  - On that ack edge, req_addr <= pending target and redir_pending is cleared.
- A new redirect while redir_pending=1 cannot occur; decode only sees bubbles. The bench asserts this.
- Low address bits: req_addr[1:0] are forced to 00.
- Wrap: 32-bit PC arithmetic wraps modulo 2^32.

Decomposition:
- Shared package: NOP_WORD constant, PC increment constant (4), request-state encoding.
- PC+4/PC+8: use the existing adder_32.
- One natural sub-module, fetch_skid_buf: the buffer plus hold register, with load/consume/flush controls.

Test Plan:
1. Reset, ack tied 1, stall 0 -> imem_addr 0,4,8 on successive cycles; after edges 1,2,3: inst_out=mem[0],mem[4],mem[8]; pc4_out=4,8,12; pc8_out=8,12,16.
2. Ack delayed 2 cycles per request -> imem_req/imem_addr stable while waiting; inst_out=0, inst_valid=0 in gap cycles; addresses advance only on ack.
3. stall high 3 cycles, ack=1 -> inst_out held; hold fills then imem_req=0; after release, the stream continues in order with no gap or duplicate.
4. Branch at 0x10 in ID, buffer holds 0x14, target 0x40, ack=1 -> decode receives 0x14 then 0x40, 0x44; word from 0x18 never appears.
5. Branch redirect with buf_valid=0, request 0x14 outstanding, ack after 3 cycles -> 0x14 delivered, next imem_addr=0x40; jr to 0x100 with squash of in-flight 0x18 -> 0x18 dropped, next valid inst from 0x100.
6. Async reset asserted mid-wait -> outputs 0 and imem_req=0 immediately; after release the first imem_addr is RESET_PC.
